// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared geometry, colour and fade-level constants for the piano key renderer
package piano_pkg;
   localparam int KEY_W   = 80;
   localparam int N_KEYS  = 16;
   localparam int KB_TOP  = 769;
   localparam int LEVEL_W = 4;

   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   localparam rgb_t COLOR_BLACK  = 12'h000;
   localparam rgb_t COLOR_BORDER = 12'h222;
endpackage

// File: rtl/piano_key_fade.sv
// rtl/piano_key_fade.sv - per-key fade level: full while held, one step down per frame once released
module piano_key_fade
   import piano_pkg::*;
(
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               held,
   input  logic               frame_tick,
   output logic [LEVEL_W-1:0] level
);

   // Held beats the frame tick so a press on a vsync edge still lands at full level.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         level <= '0;
      end else if (held) begin
         level <= LEVEL_MAX;
      end else if (frame_tick && (level != '0)) begin
         level <= level - LEVEL_W'(1);
      end
   end

endmodule

// File: rtl/piano_key_render.sv
// rtl/piano_key_render.sv - keyboard band renderer with per-key fade, two-stage pixel pipeline
module piano_key_render #(
   parameter int KEY_W  = piano_pkg::KEY_W,
   parameter int N_KEYS = piano_pkg::N_KEYS,
   parameter int KB_TOP = piano_pkg::KB_TOP
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [10:0]       xpos,
   input  logic [10:0]       ypos,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [N_KEYS-1:0] key_down,
   output logic              VGA_HSYNC,
   output logic              VGA_VSYNC,
   output logic [3:0]        VGA_RED,
   output logic [3:0]        VGA_GREEN,
   output logic [3:0]        VGA_BLUE
);
   import piano_pkg::*;

   localparam int COL_W  = (KEY_W  > 1) ? $clog2(KEY_W)  : 1;
   localparam int KEY_IW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(KEY_W - 1);
   localparam logic [KEY_IW-1:0] KEY_LAST = KEY_IW'(N_KEYS - 1);
   localparam logic [10:0]       KB_TOP_Y = 11'(KB_TOP);

   logic [COL_W-1:0]   col, col_next;
   logic [KEY_IW-1:0]  key, key_next;
   logic               vs_prev;
   logic               frame_tick;
   logic [LEVEL_W-1:0] level [N_KEYS];

   logic [10:0]        x1, y1;
   logic               hs1, vs1;
   logic [LEVEL_W-1:0] lvl1;
   rgb_t               colour;

   assign frame_tick = vsync_in & ~vs_prev;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_fade
      piano_key_fade u_fade (
         .CLK        (CLK),
         .RST_N      (RST_N),
         .held       (key_down[i]),
         .frame_tick (frame_tick),
         .level      (level[i])
      );
   end

   // Column/key counter replaces a divide by KEY_W; xpos==1 restarts the line.
   always_comb begin
      col_next = col;
      key_next = key;
      if (xpos == 11'd1) begin
         col_next = '0;
         key_next = '0;
      end else if (xpos > 11'd1) begin
         if (col == COL_LAST) begin
            col_next = '0;
            if (key != KEY_LAST) begin
               key_next = key + KEY_IW'(1);
            end
         end else begin
            col_next = col + COL_W'(1);
         end
      end
   end

   // Stage 1: position, syncs, counter and the key's level captured together.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         col     <= '0;
         key     <= '0;
         vs_prev <= 1'b0;
         x1      <= '0;
         y1      <= '0;
         hs1     <= 1'b0;
         vs1     <= 1'b0;
         lvl1    <= '0;
      end else begin
         col     <= col_next;
         key     <= key_next;
         vs_prev <= vsync_in;
         x1      <= xpos;
         y1      <= ypos;
         hs1     <= hsync_in;
         vs1     <= vsync_in;
         lvl1    <= level[key_next];
      end
   end

   always_comb begin
      colour = COLOR_BLACK;
      if ((x1 == '0) || (y1 == '0)) begin
         colour = COLOR_BLACK;
      end else if (y1 < KB_TOP_Y) begin
         colour = COLOR_BLACK;
      end else if ((col == '0) || (y1 == KB_TOP_Y)) begin
         colour = COLOR_BORDER;
      end else begin
         colour.r = 4'hF;
         colour.g = LEVEL_MAX - lvl1;
         colour.b = LEVEL_MAX - lvl1;
      end
   end

   // Stage 2: registered outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         VGA_HSYNC <= 1'b0;
         VGA_VSYNC <= 1'b0;
         VGA_RED   <= '0;
         VGA_GREEN <= '0;
         VGA_BLUE  <= '0;
      end else begin
         VGA_HSYNC <= hs1;
         VGA_VSYNC <= vs1;
         VGA_RED   <= colour.r;
         VGA_GREEN <= colour.g;
         VGA_BLUE  <= colour.b;
      end
   end

endmodule
